// File: rtl/fpu_pkg.sv
// Shared FPU encodings: opcode/func7 classes, CSR selects, fflags bit positions,
// canonical quiet NaN and the issue-controller state type.
package fpu_pkg;

   localparam logic [6:0] OP_FP     = 7'b1010011;
   localparam logic [6:0] OP_FMADD  = 7'b1000011;
   localparam logic [6:0] OP_FMSUB  = 7'b1000111;
   localparam logic [6:0] OP_FNMSUB = 7'b1001011;
   localparam logic [6:0] OP_FNMADD = 7'b1001111;

   localparam logic [6:0] F7_FADD     = 7'b0000000;
   localparam logic [6:0] F7_FCMP     = 7'b1010000;
   localparam logic [6:0] F7_FCLASS   = 7'b1110000;
   localparam logic [6:0] F7_FCVT_F2I = 7'b1100000;

   typedef enum logic [1:0] {
      CSR_FFLAGS = 2'b00,
      CSR_FRM    = 2'b01,
      CSR_FCSR   = 2'b10,
      CSR_NONE   = 2'b11
   } csr_sel_e;

   localparam int unsigned FF_NV = 4;
   localparam int unsigned FF_DZ = 3;
   localparam int unsigned FF_OF = 2;
   localparam int unsigned FF_UF = 1;
   localparam int unsigned FF_NX = 0;

   localparam logic [31:0] FP32_QNAN = 32'h7FC0_0000;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_START,
      ST_WAIT,
      ST_WB
   } issue_state_e;

   // Fused ops never target the integer file, whatever their func7 bits hold.
   function automatic logic writes_int(input logic [6:0] opcode, input logic [6:0] func7);
      logic fused;
      fused = (opcode == OP_FMADD) || (opcode == OP_FMSUB) ||
              (opcode == OP_FNMSUB) || (opcode == OP_FNMADD);
      return !fused && ((func7 == F7_FCMP) || (func7 == F7_FCLASS) || (func7 == F7_FCVT_F2I));
   endfunction

endpackage

// File: rtl/fpu_fcsr.sv
// Floating-point CSR: sticky fflags and rounding mode, with a combinational
// zero-extended read port.
module fpu_fcsr
   import fpu_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        i_csr_we,
   input  logic [1:0]  i_csr_sel,
   input  logic [31:0] i_csr_wdata,
   input  logic        i_wb_set,
   input  logic [4:0]  i_wb_flags,
   output logic [2:0]  o_frm,
   output logic [31:0] o_rdata
);

   logic [4:0] r_fflags;
   logic [2:0] r_frm;
   logic [4:0] w_fflags_wr;
   logic [2:0] w_frm_wr;
   logic       w_unused_wdata;

   assign w_unused_wdata = ^i_csr_wdata[31:8];

   always_comb begin
      w_fflags_wr = r_fflags;
      w_frm_wr    = r_frm;
      if (i_csr_we) begin
         case (csr_sel_e'(i_csr_sel))
            CSR_FFLAGS: w_fflags_wr = i_csr_wdata[4:0];
            CSR_FRM:    w_frm_wr    = i_csr_wdata[2:0];
            CSR_FCSR:   {w_frm_wr, w_fflags_wr} = i_csr_wdata[7:0];
            default:    ;
         endcase
      end
   end

   // Software write lands first; writeback flags are OR-ed on top so they survive.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_fflags <= '0;
         r_frm    <= '0;
      end else begin
         r_frm    <= w_frm_wr;
         r_fflags <= w_fflags_wr | (i_wb_set ? i_wb_flags : '0);
      end
   end

   always_comb begin
      o_rdata = '0;
      case (csr_sel_e'(i_csr_sel))
         CSR_FFLAGS: o_rdata = {27'b0, r_fflags};
         CSR_FRM:    o_rdata = {29'b0, r_frm};
         CSR_FCSR:   o_rdata = {24'b0, r_frm, r_fflags};
         default:    o_rdata = '0;
      endcase
   end

   assign o_frm = r_frm;

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Single-issue FPU sequencer: accepts one instruction, starts the FPU, waits for
// done or a timeout, then writes back one result and folds its flags into fflags.
module fpu_issue_ctrl
   import fpu_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        issue_valid,
   output logic        issue_ready,
   input  logic [6:0]  issue_opcode,
   input  logic [6:0]  issue_func7,
   input  logic [2:0]  issue_func3,
   input  logic [4:0]  issue_rs2,
   input  logic [4:0]  issue_rd,
   input  logic [31:0] issue_a,
   input  logic [31:0] issue_b,
   input  logic [31:0] issue_c,
   output logic        fpu_start,
   output logic [6:0]  fpu_opcode,
   output logic [6:0]  fpu_func7,
   output logic [2:0]  fpu_func3,
   output logic [4:0]  fpu_rs2,
   output logic [2:0]  fpu_frm,
   output logic [31:0] fpu_a,
   output logic [31:0] fpu_b,
   output logic [31:0] fpu_c,
   input  logic [31:0] fpu_result,
   input  logic [4:0]  fpu_fflags,
   input  logic        fpu_done,
   output logic        wb_valid,
   output logic [4:0]  wb_rd,
   output logic [31:0] wb_data,
   output logic        wb_to_int,
   output logic        wb_timeout,
   input  logic        csr_we,
   input  logic [1:0]  csr_sel,
   input  logic [31:0] csr_wdata,
   output logic [31:0] csr_rdata
);

   localparam int unsigned    CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   issue_state_e r_state, w_state_nxt;

   logic [6:0]       r_opcode, r_func7;
   logic [2:0]       r_func3, r_frm;
   logic [4:0]       r_rs2, r_rd, r_flags;
   logic [31:0]      r_a, r_b, r_c, r_res;
   logic [CNT_W-1:0] r_cnt;
   logic             r_timeout;

   logic       w_accept, w_done_cap, w_timeout_hit, w_busy;
   logic [2:0] w_frm;

   assign w_accept = issue_valid && (r_state == ST_IDLE);
   assign w_busy   = (r_state == ST_START) || (r_state == ST_WAIT);

   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   // Done outranks the timeout when both land on the last counted cycle.
   always_comb begin
      w_state_nxt   = r_state;
      w_done_cap    = 1'b0;
      w_timeout_hit = 1'b0;
      case (r_state)
         ST_IDLE: if (issue_valid) w_state_nxt = ST_START;
         ST_START, ST_WAIT: begin
            if (fpu_done) begin
               w_state_nxt = ST_WB;
               w_done_cap  = 1'b1;
            end else if (r_cnt == CNT_LAST) begin
               w_state_nxt   = ST_WB;
               w_timeout_hit = 1'b1;
            end else begin
               w_state_nxt = ST_WAIT;
            end
         end
         ST_WB:   w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_opcode  <= '0;
         r_func7   <= '0;
         r_func3   <= '0;
         r_rs2     <= '0;
         r_rd      <= '0;
         r_a       <= '0;
         r_b       <= '0;
         r_c       <= '0;
         r_frm     <= '0;
         r_cnt     <= '0;
         r_res     <= '0;
         r_flags   <= '0;
         r_timeout <= 1'b0;
      end else begin
         if (w_accept) begin
            r_opcode  <= issue_opcode;
            r_func7   <= issue_func7;
            r_func3   <= issue_func3;
            r_rs2     <= issue_rs2;
            r_rd      <= issue_rd;
            r_a       <= issue_a;
            r_b       <= issue_b;
            r_c       <= issue_c;
            r_frm     <= w_frm;
            r_cnt     <= '0;
            r_res     <= '0;
            r_flags   <= '0;
            r_timeout <= 1'b0;
         end
         if (w_done_cap) begin
            r_res     <= fpu_result;
            r_flags   <= fpu_fflags;
            r_timeout <= 1'b0;
         end else if (w_timeout_hit) begin
            r_res          <= FP32_QNAN;
            r_flags        <= '0;
            r_flags[FF_NV] <= 1'b1;
            r_timeout      <= 1'b1;
         end else if (w_busy) begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

   fpu_fcsr u_fcsr (
      .clk         (clk),
      .rst         (rst),
      .i_csr_we    (csr_we),
      .i_csr_sel   (csr_sel),
      .i_csr_wdata (csr_wdata),
      .i_wb_set    (r_state == ST_WB),
      .i_wb_flags  (r_flags),
      .o_frm       (w_frm),
      .o_rdata     (csr_rdata)
   );

   assign issue_ready = (r_state == ST_IDLE);
   assign fpu_start   = (r_state == ST_START);
   assign fpu_opcode  = r_opcode;
   assign fpu_func7   = r_func7;
   assign fpu_func3   = r_func3;
   assign fpu_rs2     = r_rs2;
   assign fpu_frm     = r_frm;
   assign fpu_a       = r_a;
   assign fpu_b       = r_b;
   assign fpu_c       = r_c;
   assign wb_valid    = (r_state == ST_WB);
   assign wb_rd       = r_rd;
   assign wb_data     = r_res;
   assign wb_to_int   = writes_int(r_opcode, r_func7);
   assign wb_timeout  = (r_state == ST_WB) && r_timeout;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Randomized bench for fpu_issue_ctrl against a transaction-level model of
// writeback timing, result routing and the FCSR.
module tb_fpu_issue_ctrl;

   localparam int unsigned TO = 64;

   logic        clk = 1'b0;
   logic        rst;
   logic        issue_valid, issue_ready;
   logic [6:0]  issue_opcode, issue_func7;
   logic [2:0]  issue_func3;
   logic [4:0]  issue_rs2, issue_rd;
   logic [31:0] issue_a, issue_b, issue_c;
   logic        fpu_start;
   logic [6:0]  fpu_opcode, fpu_func7;
   logic [2:0]  fpu_func3, fpu_frm;
   logic [4:0]  fpu_rs2;
   logic [31:0] fpu_a, fpu_b, fpu_c;
   logic [31:0] fpu_result;
   logic [4:0]  fpu_fflags;
   logic        fpu_done;
   logic        wb_valid, wb_to_int, wb_timeout;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        csr_we;
   logic [1:0]  csr_sel;
   logic [31:0] csr_wdata, csr_rdata;

   always #5 clk = ~clk;

   fpu_issue_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst(rst),
      .issue_valid(issue_valid), .issue_ready(issue_ready),
      .issue_opcode(issue_opcode), .issue_func7(issue_func7), .issue_func3(issue_func3),
      .issue_rs2(issue_rs2), .issue_rd(issue_rd),
      .issue_a(issue_a), .issue_b(issue_b), .issue_c(issue_c),
      .fpu_start(fpu_start), .fpu_opcode(fpu_opcode), .fpu_func7(fpu_func7),
      .fpu_func3(fpu_func3), .fpu_rs2(fpu_rs2), .fpu_frm(fpu_frm),
      .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_c(fpu_c),
      .fpu_result(fpu_result), .fpu_fflags(fpu_fflags), .fpu_done(fpu_done),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
      .wb_to_int(wb_to_int), .wb_timeout(wb_timeout),
      .csr_we(csr_we), .csr_sel(csr_sel), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata)
   );

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;
   logic [4:0]  m_fflags = '0;
   logic [2:0]  m_frm    = '0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_csr_write(input logic [1:0] sel, input logic [31:0] wd);
      case (sel)
         2'b00: m_fflags = wd[4:0];
         2'b01: m_frm = wd[2:0];
         2'b10: {m_frm, m_fflags} = wd[7:0];
         default: ;
      endcase
   endtask

   task automatic check_csr(input string tag);
      logic [31:0] exp;
      csr_we = 1'b0;
      for (int s = 0; s < 3; s++) begin
         csr_sel = 2'(s);
         #1;
         exp = (s == 0) ? {27'b0, m_fflags} : (s == 1) ? {29'b0, m_frm} : {24'b0, m_frm, m_fflags};
         chk(tag, csr_rdata, exp);
      end
   endtask

   task automatic csr_write(input logic [1:0] sel, input logic [31:0] wd);
      csr_we = 1'b1;
      csr_sel = sel;
      csr_wdata = wd;
      tick();
      csr_we = 1'b0;
      model_csr_write(sel, wd);
   endtask

   // done_dly: cycle index after fpu_start at which done is raised (>= TO means never).
   // csr_at: cycle index of a concurrent CSR write, -1 for none.
   task automatic run_instr(input logic [6:0] op, input logic [6:0] f7, input logic [2:0] f3,
                            input logic [4:0] rs2, input logic [4:0] rd,
                            input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                            input int done_dly, input logic [31:0] res, input logic [4:0] flg,
                            input int csr_at, input logic [1:0] wsel, input logic [31:0] wdat);
      int          exp_n;
      bit          tmo;
      bit          to_int;
      logic [2:0]  frm_cap;
      logic [31:0] exp_data;
      logic [4:0]  exp_flg;
      logic [24:0] exp_ctl;
      tmo      = (done_dly >= int'(TO));
      exp_n    = tmo ? int'(TO) : done_dly + 1;
      exp_data = tmo ? 32'h7FC00000 : res;
      exp_flg  = tmo ? 5'b10000 : flg;
      to_int   = !(op inside {7'b1000011, 7'b1000111, 7'b1001011, 7'b1001111}) &&
                 (f7 inside {7'b1010000, 7'b1110000, 7'b1100000});
      frm_cap  = m_frm;
      exp_ctl  = {op, f7, f3, rs2, frm_cap};

      csr_we = 1'b0;
      chk("idle_ready", 32'(issue_ready), 32'd1);
      issue_valid = 1'b1;
      issue_opcode = op; issue_func7 = f7; issue_func3 = f3;
      issue_rs2 = rs2; issue_rd = rd;
      issue_a = a; issue_b = b; issue_c = c;
      tick();
      issue_valid = 1'b0;
      issue_opcode = 7'($urandom); issue_func7 = 7'($urandom); issue_func3 = 3'($urandom);
      issue_rs2 = 5'($urandom); issue_rd = 5'($urandom);
      issue_a = $urandom; issue_b = $urandom; issue_c = $urandom;

      for (int n = 0; n <= exp_n; n++) begin
         if (n < exp_n) begin
            chk("busy_ready", 32'(issue_ready), 32'd0);
            chk("busy_wb_valid", 32'(wb_valid), 32'd0);
            chk("fpu_start", 32'(fpu_start), 32'(n == 0));
            chk("fpu_ctl", 32'({fpu_opcode, fpu_func7, fpu_func3, fpu_rs2, fpu_frm}), 32'(exp_ctl));
            chk("fpu_a", fpu_a, a);
            chk("fpu_b", fpu_b, b);
            chk("fpu_c", fpu_c, c);
            fpu_done = (n == done_dly);
            fpu_result = (n == done_dly) ? res : $urandom;
            fpu_fflags = (n == done_dly) ? flg : 5'($urandom);
         end else begin
            chk("wb_valid", 32'(wb_valid), 32'd1);
            chk("wb_rd", 32'(wb_rd), 32'(rd));
            chk("wb_data", wb_data, exp_data);
            chk("wb_to_int", 32'(wb_to_int), 32'(to_int));
            chk("wb_timeout", 32'(wb_timeout), 32'(tmo));
            chk("wb_start", 32'(fpu_start), 32'd0);
            chk("wb_ready", 32'(issue_ready), 32'd0);
            fpu_done = 1'($urandom);
            fpu_result = $urandom;
            fpu_fflags = 5'($urandom);
         end
         csr_we = (n == csr_at);
         csr_sel = wsel;
         csr_wdata = wdat;
         tick();
         if (n == csr_at) model_csr_write(wsel, wdat);
         if (n == exp_n) m_fflags = m_fflags | exp_flg;
      end
      fpu_done = 1'b0;
      csr_we = 1'b0;
      chk("post_wb_valid", 32'(wb_valid), 32'd0);
      chk("post_ready", 32'(issue_ready), 32'd1);
      check_csr("post_csr");
   endtask

   logic [6:0] op_tab [7] = '{7'b1010011, 7'b1010011, 7'b1010011,
                              7'b1000011, 7'b1000111, 7'b1001011, 7'b1001111};
   logic [6:0] f7_tab [8] = '{7'b0000000, 7'b0000100, 7'b0001000, 7'b1010000,
                              7'b1110000, 7'b1100000, 7'b1101000, 7'b0101100};

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

   initial begin
      int          dly, en, cat, r;
      logic [31:0] idle_rd;
      rst = 1'b1;
      issue_valid = 1'b0;
      issue_opcode = '0; issue_func7 = '0; issue_func3 = '0;
      issue_rs2 = '0; issue_rd = '0;
      issue_a = '0; issue_b = '0; issue_c = '0;
      fpu_result = '0; fpu_fflags = '0; fpu_done = 1'b0;
      csr_we = 1'b0; csr_sel = 2'b10; csr_wdata = '0;
      tick();
      tick();
      rst = 1'b0;
      chk("rst_ready", 32'(issue_ready), 32'd1);
      chk("rst_start", 32'(fpu_start), 32'd0);
      chk("rst_wb_valid", 32'(wb_valid), 32'd0);
      chk("rst_wb_timeout", 32'(wb_timeout), 32'd0);
      check_csr("rst_csr");

      // FADD, done three cycles after start
      run_instr(7'b1010011, 7'b0000000, 3'b000, 5'd2, 5'd5, 32'h3F800000, 32'h40000000, 32'd0,
                3, 32'h40400000, 5'b00001, -1, 2'b00, 32'd0);
      // FCMP routes to the integer file
      run_instr(7'b1010011, 7'b1010000, 3'b010, 5'd3, 5'd9, 32'h3F800000, 32'h3F800000, 32'd0,
                1, 32'd1, 5'b00000, -1, 2'b00, 32'd0);
      // no done at all: timeout writeback
      run_instr(7'b1010011, 7'b0001100, 3'b000, 5'd4, 5'd7, 32'h1, 32'h2, 32'h3,
                TO + 10, 32'h12345678, 5'b00000, -1, 2'b00, 32'd0);
      // fflags cleared by software in the WB cycle
      run_instr(7'b1010011, 7'b0000100, 3'b000, 5'd1, 5'd3, 32'h5, 32'h6, 32'h7,
                2, 32'h0BADF00D, 5'b10000, 3, 2'b00, 32'd0);
      // frm via fcsr, then issue uses it
      csr_write(2'b10, 32'h0000_0060);
      check_csr("fcsr_frm");
      run_instr(7'b1010011, 7'b0001000, 3'b111, 5'd0, 5'd12, 32'hAA, 32'hBB, 32'hCC,
                0, 32'h3F000000, 5'b00100, -1, 2'b00, 32'd0);
      // ignored sel 11 write
      csr_write(2'b11, 32'hFFFF_FFFF);
      check_csr("sel3_ignored");

      // stray done while idle
      for (int i = 0; i < 3; i++) begin
         fpu_done = 1'b1;
         fpu_result = $urandom;
         fpu_fflags = 5'b11111;
         tick();
         chk("stray_wb_valid", 32'(wb_valid), 32'd0);
         chk("stray_ready", 32'(issue_ready), 32'd1);
      end
      fpu_done = 1'b0;
      check_csr("stray_csr");

      // reset during WAIT discards the instruction
      issue_valid = 1'b1;
      issue_opcode = 7'b1010011; issue_func7 = 7'b0000000; issue_rd = 5'd20;
      issue_a = 32'h11; issue_b = 32'h22; issue_c = 32'h33;
      tick();
      issue_valid = 1'b0;
      tick();
      chk("pre_rst_busy", 32'(issue_ready), 32'd0);
      rst = 1'b1;
      fpu_done = 1'b1;
      fpu_result = 32'hDEADBEEF;
      fpu_fflags = 5'b11111;
      tick();
      rst = 1'b0;
      m_fflags = '0;
      m_frm = '0;
      chk("rstw_wb_valid", 32'(wb_valid), 32'd0);
      chk("rstw_ready", 32'(issue_ready), 32'd1);
      chk("rstw_start", 32'(fpu_start), 32'd0);
      chk("rstw_wb_data", wb_data, 32'd0);
      chk("rstw_fpu_a", fpu_a, 32'd0);
      tick();
      fpu_done = 1'b0;
      chk("rstw_wb_valid2", 32'(wb_valid), 32'd0);
      chk("rstw_ready2", 32'(issue_ready), 32'd1);
      check_csr("rstw_csr");

      for (int t = 0; t < 40; t++) begin
         r = int'($urandom_range(0, 9));
         dly = (r == 0) ? int'(TO) + int'($urandom_range(0, 5)) :
               (r == 1) ? int'(TO) - 1 :
               (r == 2) ? int'(TO) - 2 : int'($urandom_range(0, 6));
         en  = (dly >= int'(TO)) ? int'(TO) : dly + 1;
         cat = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, en));
         run_instr(op_tab[$urandom_range(0, 6)], f7_tab[$urandom_range(0, 7)], 3'($urandom),
                   5'($urandom), 5'($urandom), $urandom, $urandom, $urandom,
                   dly, $urandom, 5'($urandom), cat, 2'($urandom), $urandom);
         if ($urandom_range(0, 3) == 0) begin
            csr_write(2'($urandom), $urandom);
            check_csr("rand_idle_csr");
         end
         if ($urandom_range(0, 3) == 0) begin
            idle_rd = {24'b0, m_frm, m_fflags};
            fpu_done = 1'b1;
            fpu_fflags = 5'($urandom);
            tick();
            fpu_done = 1'b0;
            chk("rand_stray_wb", 32'(wb_valid), 32'd0);
            csr_sel = 2'b10;
            #1;
            chk("rand_stray_csr", csr_rdata, idle_rd);
         end
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/fpu_issue_ctrl.md
FPU_ISSUE_CTRL -- requirements
Module: fpu_issue_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 64, meaning the maximum number of cycles to wait for fpu_done before aborting.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have ports issue_valid (input, 1) and issue_ready (output, 1): the decode-side instruction handshake.
REQ-005 SHALL have inputs issue_opcode[6:0], issue_func7[6:0], issue_func3[2:0], issue_rs2[4:0], issue_rd[4:0], and issue_a/issue_b/issue_c[31:0].
REQ-006 SHALL have outputs fpu_start (1), fpu_opcode[6:0], fpu_func7[6:0], fpu_func3[2:0], fpu_rs2[4:0], fpu_frm[2:0] and fpu_a/fpu_b/fpu_c[31:0], all driving the FPU.
REQ-007 SHALL have FPU-return inputs fpu_result[31:0], fpu_fflags[4:0] (NV,DZ,OF,UF,NX) and fpu_done (1).
REQ-008 SHALL have writeback outputs wb_valid (1), wb_rd[4:0], wb_data[31:0], wb_to_int (1; 1 = integer regfile, 0 = FP regfile) and wb_timeout (1).
REQ-009 SHALL have CSR port inputs csr_we (1), csr_sel[1:0] (00 fflags, 01 frm, 10 fcsr) and csr_wdata[31:0], plus output csr_rdata[31:0].

Function
REQ-010 SHALL implement the FSM IDLE -> START -> WAIT -> WB -> IDLE.
REQ-011 SHALL hold issue_ready=1 only in IDLE, and SHALL accept an instruction on issue_valid&&issue_ready, latching all issue_* fields and moving to START.
REQ-012 SHALL hold the fpu_* operand and control outputs stable from START until leaving WAIT.
REQ-013 SHALL assert fpu_start for exactly one cycle, in START, and SHALL drive fpu_frm from the internal frm register.
REQ-014 SHALL treat fpu_done sampled in START or WAIT as completion: latch fpu_result and fpu_fflags, then enter WB.
REQ-015 SHALL ignore fpu_done in IDLE and WB, with no state, flag or writeback effect.
REQ-016 SHALL hold wb_valid=1 for exactly one cycle, in WB, with wb_rd equal to the latched rd and wb_data equal to the latched result; WB SHALL return to IDLE unconditionally.
REQ-017 SHALL set wb_to_int=1 when opcode is not fused (1000011/1000111/1001011/1001111) and func7 is 1010000 (compare), 1110000 (class) or 1100000 (FP-to-int); otherwise 0.
REQ-018 SHALL count cycles in START and WAIT; on reaching TIMEOUT_CYCLES without done it SHALL enter WB with wb_data=32'h7FC00000, wb_timeout=1 and NV added to the captured flags.
REQ-019 SHALL set fflags |= captured flags in the WB cycle (sticky accumulation).
REQ-020 SHALL apply a CSR write first and then OR in WB flags when both occur in the same cycle, so the WB flags are never lost.
REQ-021 SHALL, on a CSR write, update fflags=wdata[4:0] (sel 00), frm=wdata[2:0] (sel 01), or {frm,fflags}=wdata[7:0] (sel 10); sel 11 SHALL be ignored.
REQ-022 SHALL drive csr_rdata combinationally and zero-extended: {27'b0,fflags}, {29'b0,frm} or {24'b0,frm,fflags}.
REQ-023 SHALL apply frm writes made during START/WAIT to subsequent instructions only, not to the in-flight one.

Reset
REQ-024 SHALL, while rst=1 at a clock edge: enter IDLE, clear fflags, frm, the counter and all latches, and drive fpu_start=0, wb_valid=0, wb_timeout=0, issue_ready=1 (outputs 0 otherwise).
REQ-025 SHALL, on reset during START/WAIT/WB, discard the in-flight instruction with no writeback and no flag update.

Structure
REQ-026 SHALL place opcode/func7 localparams, the csr_sel encodings, the fflags bit positions and the QNaN constant in a shared package fpu_pkg, for reuse by the FPU top level.
REQ-027 SHALL be a single module with no sub-module; the FCSR register MAY be split out as fpu_fcsr.

Verification
REQ-028 SHALL cover: issue FADD (func7 0000000, rd=5), done after 3 cycles with result 0x40400000 and flags 00001 -> one fpu_start pulse, wb_valid with rd=5, data 0x40400000, wb_to_int=0, fflags=00001.
REQ-029 SHALL cover: issue FCMP (func7 1010000) with result 1 -> wb_to_int=1, wb_data=1, issue_ready=0 until IDLE.
REQ-030 SHALL cover: no done for 64 cycles -> WB with data 0x7FC00000, wb_timeout=1, fflags[4]=1.
REQ-031 SHALL cover: CSR write fflags=0 in the same cycle as WB with flags 10000 -> fflags=10000.
REQ-032 SHALL cover: rst asserted in WAIT, then fpu_done -> no wb_valid, IDLE, fflags=0.
REQ-033 SHALL cover: frm=011 written via fcsr sel, then issue -> fpu_frm=011; stray fpu_done in IDLE -> no effect.
